// File: rtl/pc_sequencer.sv
// Program-counter sequencer for picoMIPS: picks increment, load or hold each cycle.
// Also stretches MUL over several cycles and runs the switch-input handshake.
module pc_sequencer #(
    parameter int P_SIZE     = 4,
    parameter int MUL_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [P_SIZE-1:0] pcAddress,
    input  logic [2:0]        opClass,
    input  logic              zeroFlag,
    input  logic [P_SIZE-1:0] offset,
    input  logic              inValid,
    output logic              inReady,
    output logic              pcInc,
    output logic              pcLoad,
    output logic [P_SIZE-1:0] pcTarget,
    output logic              regWrite,
    output logic              halted
);

    localparam int CW       = $clog2(MUL_CYCLES) + 1;
    localparam int MUL_LOAD = (MUL_CYCLES >= 2) ? MUL_CYCLES - 2 : 0;

    localparam logic [2:0] S_RUN     = 3'd0;
    localparam logic [2:0] S_MULWAIT = 3'd1;
    localparam logic [2:0] S_INWAIT  = 3'd2;
    localparam logic [2:0] S_INREL   = 3'd3;
    localparam logic [2:0] S_HALT    = 3'd4;

    localparam logic [2:0] OP_ALU  = 3'd0;
    localparam logic [2:0] OP_MUL  = 3'd1;
    localparam logic [2:0] OP_BEQ  = 3'd2;
    localparam logic [2:0] OP_BNE  = 3'd3;
    localparam logic [2:0] OP_JMP  = 3'd4;
    localparam logic [2:0] OP_WAIT = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          taken;

    assign taken = (opClass == OP_BEQ) ? zeroFlag : ~zeroFlag;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        inReady  = 1'b0;
        pcInc    = 1'b0;
        pcLoad   = 1'b0;
        pcTarget = '0;
        regWrite = 1'b0;
        halted   = 1'b0;
        case (state_q)
            S_RUN: begin
                case (opClass)
                    OP_ALU: begin
                        pcInc    = 1'b1;
                        regWrite = 1'b1;
                    end
                    OP_MUL: begin
                        if (MUL_CYCLES == 1) begin
                            pcInc    = 1'b1;
                            regWrite = 1'b1;
                        end else begin
                            cnt_d   = MUL_LOAD[CW-1:0];
                            state_d = S_MULWAIT;
                        end
                    end
                    OP_BEQ, OP_BNE: begin
                        if (taken) begin
                            pcLoad   = 1'b1;
                            pcTarget = pcAddress + offset;
                        end else begin
                            pcInc = 1'b1;
                        end
                    end
                    OP_JMP: begin
                        pcLoad   = 1'b1;
                        pcTarget = offset;
                    end
                    OP_WAIT: state_d = S_INWAIT;
                    OP_HALT: state_d = S_HALT;
                    default: pcInc = 1'b1;
                endcase
            end
            S_MULWAIT: begin
                if (cnt_q == '0) begin
                    pcInc    = 1'b1;
                    regWrite = 1'b1;
                    state_d  = S_RUN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_INWAIT: begin
                if (inValid) begin
                    inReady  = 1'b1;
                    regWrite = 1'b1;
                    state_d  = S_INREL;
                end
            end
            S_INREL: begin
                if (inValid) begin
                    inReady = 1'b1;
                end else begin
                    pcInc   = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_HALT:  halted = 1'b1;
            default: state_d = S_RUN;
        endcase
        // Outputs are silent for the whole time reset is held.
        if (reset) begin
            inReady  = 1'b0;
            pcInc    = 1'b0;
            pcLoad   = 1'b0;
            pcTarget = '0;
            regWrite = 1'b0;
            halted   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised and directed bench for pc_sequencer (MUL_CYCLES=3),
// checked against a cycle-level behavioural model of the instruction rules.
module tb_pc_sequencer;

    localparam int P   = 4;
    localparam int MC  = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [P-1:0] pcAddress;
    logic [2:0]   opClass;
    logic         zeroFlag;
    logic [P-1:0] offset;
    logic         inValid;
    logic         inReady;
    logic         pcInc;
    logic         pcLoad;
    logic [P-1:0] pcTarget;
    logic         regWrite;
    logic         halted;

    int errors = 0;
    int checks = 0;

    // Model: remaining MUL cycles after the issuing one, handshake phase, halt.
    int m_mul_left = 0;
    bit m_wait     = 0;
    bit m_rel      = 0;
    bit m_halt     = 0;

    pc_sequencer #(.P_SIZE(P), .MUL_CYCLES(MC)) dut (
        .clk      (clk),
        .reset    (reset),
        .pcAddress(pcAddress),
        .opClass  (opClass),
        .zeroFlag (zeroFlag),
        .offset   (offset),
        .inValid  (inValid),
        .inReady  (inReady),
        .pcInc    (pcInc),
        .pcLoad   (pcLoad),
        .pcTarget (pcTarget),
        .regWrite (regWrite),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Packed as {inReady, pcInc, pcLoad, pcTarget, regWrite, halted}.
    function automatic logic [8:0] model_out();
        bit ir = 0, inc = 0, ld = 0, rw = 0, h = 0;
        int tgt = 0;
        int so;
        if (reset) return '0;
        if (m_halt) begin
            h = 1;
        end else if (m_mul_left > 0) begin
            if (m_mul_left == 1) begin
                inc = 1;
                rw  = 1;
            end
        end else if (m_rel) begin
            if (inValid) ir = 1;
            else inc = 1;
        end else if (m_wait) begin
            if (inValid) begin
                ir = 1;
                rw = 1;
            end
        end else begin
            case (int'(opClass))
                0: begin inc = 1; rw = 1; end
                1: if (MC == 1) begin inc = 1; rw = 1; end
                2, 3: begin
                    if ((opClass == 3'd2) == (zeroFlag == 1'b1)) begin
                        so  = (int'(offset) >= 8) ? int'(offset) - 16
                                                  : int'(offset);
                        tgt = ((int'(pcAddress) + so) % 16 + 16) % 16;
                        ld  = 1;
                    end else begin
                        inc = 1;
                    end
                end
                4: begin ld = 1; tgt = int'(offset); end
                7: inc = 1;
                default: ;
            endcase
        end
        return {ir, inc, ld, tgt[3:0], rw, h};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mul_left = 0;
            m_wait     = 0;
            m_rel      = 0;
            m_halt     = 0;
        end else if (m_halt) begin
            m_halt = 1;
        end else if (m_mul_left > 0) begin
            m_mul_left = m_mul_left - 1;
        end else if (m_rel) begin
            if (!inValid) m_rel = 0;
        end else if (m_wait) begin
            if (inValid) begin
                m_wait = 0;
                m_rel  = 1;
            end
        end else begin
            if (opClass == 3'd1 && MC > 1) m_mul_left = MC - 1;
            if (opClass == 3'd5) m_wait = 1;
            if (opClass == 3'd6) m_halt = 1;
        end
    end

    task automatic cyc(input logic [2:0] op, input logic zf,
                       input logic [3:0] pc, input logic [3:0] off,
                       input logic iv, input logic rs, input string tag);
        @(negedge clk);
        opClass   = op;
        zeroFlag  = zf;
        pcAddress = pc;
        offset    = off;
        inValid   = iv;
        reset     = rs;
        #1;
        check(tag, {inReady, pcInc, pcLoad, pcTarget, regWrite, halted},
              model_out());
        check({tag, "_excl"}, pcInc & pcLoad, 0);
    endtask

    initial begin
        reset = 1'b1;
        opClass = 3'd7; zeroFlag = 0; pcAddress = 0; offset = 0; inValid = 0;
        cyc(3'd0, 0, 0, 0, 0, 1, "rst");
        check("rst_zero", {inReady, pcInc, pcLoad, pcTarget, regWrite, halted}, 0);

        for (int i = 0; i < 4; i++) begin
            cyc(3'd0, 0, 4'(i), 0, 0, 0, "alu");
            check("alu_inc", {pcInc, regWrite, pcLoad}, 3'b110);
        end

        cyc(3'd1, 0, 0, 0, 0, 0, "mul0");
        check("mul0_o", {pcInc, regWrite}, 2'b00);
        cyc(3'd0, 0, 0, 0, 0, 0, "mul1");
        check("mul1_o", {pcInc, regWrite}, 2'b00);
        cyc(3'd6, 0, 0, 0, 0, 0, "mul2");
        check("mul2_o", {pcInc, regWrite}, 2'b11);
        cyc(3'd0, 0, 0, 0, 0, 0, "mul3");
        check("mul3_run", {pcInc, regWrite}, 2'b11);

        cyc(3'd2, 1, 4'd14, 4'd3, 0, 0, "beq_t");
        check("beq_tgt", {pcLoad, pcTarget}, 5'b1_0001);
        cyc(3'd2, 0, 4'd14, 4'd3, 0, 0, "beq_n");
        check("beq_nt", {pcInc, pcLoad}, 2'b10);
        cyc(3'd3, 0, 4'd1, 4'b1110, 0, 0, "bne_t");
        check("bne_tgt", {pcLoad, pcTarget}, 5'b1_1111);
        cyc(3'd4, 0, 4'd3, 4'd9, 0, 0, "jmp");
        check("jmp_tgt", {pcLoad, pcTarget}, 5'b1_1001);

        cyc(3'd5, 0, 0, 0, 0, 0, "wait");
        for (int i = 0; i < 5; i++) begin
            cyc(3'd0, 0, 0, 0, 0, 0, "inwait");
            check("inwait_0", {inReady, pcInc, pcLoad, regWrite}, 0);
        end
        cyc(3'd0, 0, 0, 0, 1, 0, "inacc");
        check("inacc_o", {inReady, regWrite, pcInc}, 3'b110);
        for (int i = 0; i < 3; i++) begin
            cyc(3'd0, 0, 0, 0, 1, 0, "inrel");
            check("inrel_o", {inReady, regWrite, pcInc}, 3'b100);
        end
        cyc(3'd5, 0, 0, 0, 0, 0, "indone");
        check("indone_o", {inReady, regWrite, pcInc}, 3'b001);
        cyc(3'd7, 0, 0, 0, 0, 0, "nop");

        cyc(3'd6, 0, 0, 0, 0, 0, "halt");
        for (int i = 0; i < 10; i++) begin
            cyc(3'(i), 1, 4'(i), 4'(i), 1, 0, "halted");
            check("halted_o", {halted, pcInc, pcLoad, regWrite}, 4'b1000);
        end
        cyc(3'd0, 0, 0, 0, 0, 1, "hrst");
        check("hrst_h", halted, 0);
        cyc(3'd0, 0, 0, 0, 0, 0, "hrun");
        check("hrun_inc", pcInc, 1);

        cyc(3'd1, 0, 0, 0, 0, 0, "rm0");
        cyc(3'd1, 0, 0, 0, 0, 0, "rm1");
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rm_rst", {inReady, pcInc, pcLoad, pcTarget, regWrite}, 0);
        cyc(3'd1, 0, 0, 0, 0, 1, "rm_hold");
        cyc(3'd1, 0, 0, 0, 0, 0, "rm_a");
        check("rm_a_o", pcInc, 0);
        cyc(3'd0, 0, 0, 0, 0, 0, "rm_b");
        check("rm_b_o", pcInc, 0);
        cyc(3'd0, 0, 0, 0, 0, 0, "rm_c");
        check("rm_c_o", pcInc, 1);

        for (int i = 0; i < 400; i++) begin
            logic [2:0] op;
            logic       rs;
            op = 3'($urandom_range(0, 7));
            if (op == 3'd6 && $urandom_range(0, 3) != 0) op = 3'd0;
            rs = ($urandom_range(0, 39) == 0);
            cyc(op, 1'($urandom), 4'($urandom), 4'($urandom),
                ($urandom_range(0, 2) != 0), rs, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
